// File: rtl/wb_memtest.sv
// Wishbone classic memory tester: writes an LFSR pattern over WORDS words, reads it back,
// and reports mismatches, the first failing address, and missing acks.
module wb_memtest #(
    parameter logic [24:0] BASE    = 25'h0000000,
    parameter int unsigned WORDS   = 1024,
    parameter logic [31:0] SEED    = 32'h1234_5678,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned GAP     = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [24:0] first_err_adr,
    output logic [24:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam logic [24:0] BASE_ADR = {BASE[24:2], 2'b00};
    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam int          CW       = 24;
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam int          GW       = $clog2(GAP + 1);
    localparam logic [CW-1:0] WORDS_N      = CW'(WORDS);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FINISH} state_t;

    state_t          state;
    state_t          next_state;
    logic [24:0]     adr;
    logic [31:0]     lfsr;
    logic [CW-1:0]   word_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            in_req;
    logic            in_gap;
    logic            acked;
    logic            expired;
    logic            gap_end;
    logic            last_word;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'h0);
    endfunction

    // Bus strobes come straight from the state register so reset drops them asynchronously.
    assign in_req    = (state == WR_REQ) || (state == RD_REQ);
    assign in_gap    = (state == WR_GAP) || (state == RD_GAP);
    assign acked     = in_req && wb_ack_i;
    assign expired   = in_req && !wb_ack_i && (wait_cnt == TIMEOUT_LAST);
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign last_word = (word_cnt == WORDS_N);

    assign wb_cyc_o = in_req;
    assign wb_stb_o = in_req;
    assign wb_we_o  = (state == WR_REQ);
    assign wb_sel_o = 4'hF;
    assign wb_adr_o = adr;
    assign wb_dat_o = (state == WR_REQ) ? lfsr : 32'h0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WR_REQ;
            WR_REQ:  if (acked) next_state = WR_GAP;
                     else if (expired) next_state = FINISH;
            WR_GAP:  if (gap_end) next_state = last_word ? RD_REQ : WR_REQ;
            RD_REQ:  if (acked) next_state = RD_GAP;
                     else if (expired) next_state = FINISH;
            RD_GAP:  if (gap_end) next_state = last_word ? FINISH : RD_REQ;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr           <= '0;
            lfsr          <= '0;
            word_cnt      <= '0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_adr <= '0;
        end else begin
            wait_cnt <= in_req ? wait_cnt + 1'b1 : '0;
            gap_cnt  <= in_gap ? gap_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        adr           <= BASE_ADR;
                        lfsr          <= SEED;
                        word_cnt      <= '0;
                        err_count     <= '0;
                        first_err_adr <= '0;
                        timeout       <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (acked) begin
                        lfsr     <= lfsr_step(lfsr);
                        adr      <= adr + 25'd4;
                        word_cnt <= word_cnt + 1'b1;
                    end else if (expired) begin
                        timeout <= 1'b1;
                    end
                end
                WR_GAP: begin
                    if (gap_end && last_word) begin
                        adr      <= BASE_ADR;
                        lfsr     <= SEED;
                        word_cnt <= '0;
                    end
                end
                RD_REQ: begin
                    if (acked) begin
                        // Only the very first mismatch latches its address.
                        if (wb_dat_i != lfsr) begin
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            if (err_count == 16'h0000) first_err_adr <= adr;
                        end
                        lfsr     <= lfsr_step(lfsr);
                        adr      <= adr + 25'd4;
                        word_cnt <= word_cnt + 1'b1;
                    end else if (expired) begin
                        timeout <= 1'b1;
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 16'h0000) && !timeout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_memtest.sv
// Directed bench for wb_memtest: two instances with small ideal memories, one of them
// configured to wrap the 25-bit address space.
module tb_wb_memtest;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        start_a = 1'b0, busy_a, done_a, pass_a, tmo_a;
    logic [15:0] errc_a;
    logic [24:0] ferr_a, adr_a;
    logic [31:0] dato_a, dati_a;
    logic        we_a, stb_a, cyc_a;
    logic [3:0]  sel_a;
    logic        ack_a = 1'b0;

    logic        start_b = 1'b0, busy_b, done_b, pass_b, tmo_b;
    logic [15:0] errc_b;
    logic [24:0] ferr_b, adr_b;
    logic [31:0] dato_b, dati_b;
    logic        we_b, stb_b, cyc_b;
    logic [3:0]  sel_b;
    logic        ack_b = 1'b0;

    wb_memtest #(.BASE(25'h0000000), .WORDS(4), .SEED(32'h1234_5678), .TIMEOUT(16), .GAP(2)) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .timeout(tmo_a), .err_count(errc_a), .first_err_adr(ferr_a),
        .wb_adr_o(adr_a), .wb_dat_o(dato_a), .wb_dat_i(dati_a), .wb_we_o(we_a), .wb_sel_o(sel_a),
        .wb_stb_o(stb_a), .wb_cyc_o(cyc_a), .wb_ack_i(ack_a)
    );

    wb_memtest #(.BASE(25'h1FFFFF8), .WORDS(4), .SEED(32'h0000_0001), .TIMEOUT(16), .GAP(2)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .timeout(tmo_b), .err_count(errc_b), .first_err_adr(ferr_b),
        .wb_adr_o(adr_b), .wb_dat_o(dato_b), .wb_dat_i(dati_b), .wb_we_o(we_b), .wb_sel_o(sel_b),
        .wb_stb_o(stb_b), .wb_cyc_o(cyc_b), .wb_ack_i(ack_b)
    );

    // Slave A: mode 0 = 1-cycle ack, 1 = never ack, 2 = ack held one cycle past cyc.
    int          ack_mode = 0;
    logic        corrupt = 1'b0;
    logic [31:0] mem_a [4];
    int          n_a = 0, rise_a = 0, run_a = 0, last_run_a = 0;
    logic        prev_cyc_a = 1'b0;
    logic        log_we_a [128];
    logic [24:0] log_adr_a [128];
    logic [31:0] log_dat_a [128];

    assign dati_a = mem_a[adr_a[3:2]] ^ {31'b0, corrupt && (adr_a == 25'h8)};

    always @(posedge clk) begin
        case (ack_mode)
            0:       ack_a <= cyc_a && stb_a && !ack_a;
            1:       ack_a <= 1'b0;
            default: ack_a <= cyc_a && stb_a;
        endcase
        if (cyc_a && ack_a) begin
            if (we_a) mem_a[adr_a[3:2]] <= dato_a;
            if (n_a < 128) begin
                log_we_a[n_a]  <= we_a;
                log_adr_a[n_a] <= adr_a;
                log_dat_a[n_a] <= we_a ? dato_a : dati_a;
            end
            n_a <= n_a + 1;
        end
        prev_cyc_a <= cyc_a;
        if (cyc_a && !prev_cyc_a) rise_a <= rise_a + 1;
        run_a <= cyc_a ? run_a + 1 : 0;
        if (!cyc_a && prev_cyc_a) last_run_a <= run_a;
    end

    logic [31:0] mem_b [4];
    int          n_b = 0;
    logic [24:0] log_adr_b [16];
    logic [31:0] log_dat_b [16];

    assign dati_b = mem_b[adr_b[3:2]];

    always @(posedge clk) begin
        ack_b <= cyc_b && stb_b && !ack_b;
        if (cyc_b && ack_b) begin
            if (we_b) mem_b[adr_b[3:2]] <= dato_b;
            if (n_b < 16) begin
                log_adr_b[n_b] <= adr_b;
                log_dat_b[n_b] <= we_b ? dato_b : dati_b;
            end
            n_b <= n_b + 1;
        end
    end

    logic [31:0] exp_dat_a [4] = '{32'h1234_5678, 32'h091A_2B3C, 32'h048D_159E, 32'h0246_8ACF};
    logic [31:0] exp_dat_b [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    logic [24:0] exp_adr_b [4] = '{25'h1FFFFF8, 25'h1FFFFFC, 25'h0000000, 25'h0000004};

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic use_b);
        @(posedge clk); #1;
        if (use_b) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitDone(input logic use_b, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (use_b ? done_b : done_a) break;
            @(posedge clk); #1;
        end
        checkOutput(tag, use_b ? done_b : done_a, 1);
    endtask

    int base, rb;

    initial begin
        #2 rst_n = 1'b0;
        #10;
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_pass", pass_a, 0);
        checkOutput("rst_tmo", tmo_a, 0);
        checkOutput("rst_errc", errc_a, 0);
        checkOutput("rst_ferr", ferr_a, 0);
        checkOutput("rst_adr", adr_a, 0);
        checkOutput("rst_dat", dato_a, 0);
        checkOutput("rst_bus", {we_a, stb_a, cyc_a}, 0);
        checkOutput("rst_sel", sel_a, 4'hF);
        #10 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_cyc", cyc_a, 0);
        checkOutput("idle_busy", busy_a, 0);

        // Clean pass over four words.
        base = n_a;
        applyStimulus(1'b0);
        checkOutput("t1_busy", busy_a, 1);
        checkOutput("t1_cyc", cyc_a, 1);
        waitDone(1'b0, "t1_done");
        checkOutput("t1_acks", n_a - base, 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1_we%0d", i), log_we_a[base + i], (i < 4) ? 1 : 0);
            checkOutput($sformatf("t1_adr%0d", i), log_adr_a[base + i], (i % 4) * 4);
            checkOutput($sformatf("t1_dat%0d", i), log_dat_a[base + i], exp_dat_a[i % 4]);
        end
        checkOutput("t1_pass", pass_a, 1);
        checkOutput("t1_errc", errc_a, 0);
        checkOutput("t1_busy_end", busy_a, 0);

        // Bit 0 flipped on the read of address 8.
        corrupt = 1'b1;
        applyStimulus(1'b0);
        checkOutput("t2_done_clr", done_a, 0);
        waitDone(1'b0, "t2_done");
        checkOutput("t2_errc", errc_a, 1);
        checkOutput("t2_ferr", ferr_a, 25'h8);
        checkOutput("t2_pass", pass_a, 0);
        checkOutput("t2_tmo", tmo_a, 0);
        corrupt = 1'b0;

        // Slave never acks.
        ack_mode = 1;
        applyStimulus(1'b0);
        waitDone(1'b0, "t3_done");
        checkOutput("t3_cyc_len", last_run_a, 16);
        checkOutput("t3_tmo", tmo_a, 1);
        checkOutput("t3_pass", pass_a, 0);
        checkOutput("t3_errc", errc_a, 0);
        checkOutput("t3_ferr", ferr_a, 0);

        // Ack lingers into the first gap cycle.
        ack_mode = 2;
        base = n_a;
        rb = rise_a;
        applyStimulus(1'b0);
        waitDone(1'b0, "t4_done");
        checkOutput("t4_trans", rise_a - rb, 8);
        checkOutput("t4_acks", n_a - base, 8);
        checkOutput("t4_pass", pass_a, 1);
        checkOutput("t4_tmo", tmo_a, 0);
        ack_mode = 0;

        // Address wrap at the top of the 25-bit space.
        applyStimulus(1'b1);
        waitDone(1'b1, "t5_done");
        checkOutput("t5_acks", n_b, 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t5_adr%0d", i), log_adr_b[i], exp_adr_b[i % 4]);
            checkOutput($sformatf("t5_dat%0d", i), log_dat_b[i], exp_dat_b[i % 4]);
        end
        checkOutput("t5_pass", pass_b, 1);

        // Reset pulse in the middle of a read request.
        applyStimulus(1'b0);
        for (int i = 0; i < 100 && !(cyc_a && !we_a); i++) begin
            @(posedge clk); #1;
        end
        checkOutput("t6_rd_seen", cyc_a && !we_a, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_cyc", cyc_a, 0);
        checkOutput("t6_stb", stb_a, 0);
        checkOutput("t6_busy", busy_a, 0);
        checkOutput("t6_adr", adr_a, 0);
        checkOutput("t6_done", done_a, 0);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_idle_cyc", cyc_a, 0);
        applyStimulus(1'b0);
        waitDone(1'b0, "t6_done2");
        checkOutput("t6_pass", pass_a, 1);
        checkOutput("t6_errc", errc_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
